// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the registered one-hot decoder / line-scan sequencer.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2,
      BLANK  = 2'd3
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   function automatic int unsigned out_w(input int unsigned sel_w);
      return 32'd1 << sel_w;
   endfunction

endpackage

// File: rtl/decoder_scan_onehot.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable; all-zero when disabled.
module decoder_onehot
   import decoder_pkg::*;
#(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]        i_sel,
   input  logic                    i_en,
   output logic [out_w(SEL_W)-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_sel] = 1'b1;
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct and self-sequenced scan modes.
// Define DECODER_SCAN_BLANK_EN to insert one all-zero cycle on every scan advance.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [DWELL_W-1:0]      dwell,
   input  logic [SEL_W-1:0]        last_line,
   output logic [out_w(SEL_W)-1:0] out,
   output logic [SEL_W-1:0]        cur_sel,
   output logic                    wrap
);

   localparam int OUT_W = out_w(SEL_W);

   state_e             r_state;
   logic [DWELL_W-1:0] r_cnt;
   logic [SEL_W-1:0]   r_sel;
   logic [OUT_W-1:0]   r_out;
   logic               r_wrap;

   state_e             w_state_nxt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [SEL_W-1:0]   w_adv_sel;
   logic               w_out_en;
   logic               w_wrap_nxt;
   logic [OUT_W-1:0]   w_onehot;

   // ">=" also catches last_line lowered below the line currently driven
   assign w_adv_sel = (r_sel >= last_line) ? '0 : r_sel + SEL_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_out_en    = 1'b0;
      w_wrap_nxt  = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_sel_nxt   = '0;
      end else if (mode == MODE_DIRECT) begin
         w_state_nxt = DIRECT;
         w_cnt_nxt   = '0;
         w_sel_nxt   = sel;
         w_out_en    = 1'b1;
      end else begin
         case (r_state)
            SCAN: begin
               if (r_cnt < dwell) begin
                  w_cnt_nxt = r_cnt + DWELL_W'(1);
                  w_out_en  = 1'b1;
               end else begin
                  w_cnt_nxt = '0;
                  w_sel_nxt = w_adv_sel;
`ifdef DECODER_SCAN_BLANK_EN
                  w_state_nxt = BLANK;
`else
                  w_out_en   = 1'b1;
                  w_wrap_nxt = (w_adv_sel == '0);
`endif
               end
            end
`ifdef DECODER_SCAN_BLANK_EN
            // BLANK is only reached by an advance, so line 0 here means a wrap
            BLANK: begin
               w_state_nxt = SCAN;
               w_cnt_nxt   = '0;
               w_out_en    = 1'b1;
               w_wrap_nxt  = (r_sel == '0);
            end
`endif
            default: begin
               w_state_nxt = SCAN;
               w_cnt_nxt   = '0;
               w_sel_nxt   = '0;
               w_out_en    = 1'b1;
            end
         endcase
      end
   end

   decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
      .i_sel    (w_sel_nxt),
      .i_en     (w_out_en),
      .o_onehot (w_onehot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_out   <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
         r_out   <= w_onehot;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign out     = r_out;
   assign cur_sel = r_sel;
   assign wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=3, DWELL_W=8); follows DECODER_SCAN_BLANK_EN.
module tb_decoder_scan;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, mode;
   logic [2:0] sel, last_line, cur_sel;
   logic [7:0] dwell, out;
   logic       wrap;

   int n_chk = 0;
   int n_err = 0;

   decoder_scan #(.SEL_W(3), .DWELL_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
      .dwell(dwell), .last_line(last_line), .out(out), .cur_sel(cur_sel), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] f_out [13];
   int         f_cur [13];
   int         f_n;
   bit         found;

   initial begin
`ifdef DECODER_SCAN_BLANK_EN
      f_out = '{8'h01,8'h01,8'h00,8'h02,8'h02,8'h00,8'h04,8'h04,8'h00,8'h08,8'h08,8'h00,8'h01};
      f_cur = '{0,0,1,1,1,2,2,2,3,3,3,0,0};
      f_n   = 13;
`else
      f_out = '{8'h01,8'h01,8'h02,8'h02,8'h04,8'h04,8'h08,8'h08,8'h01,8'h00,8'h00,8'h00,8'h00};
      f_cur = '{0,0,1,1,2,2,3,3,0,0,0,0,0};
      f_n   = 9;
`endif
      rst_n = 1'b0; enable = 1'b0; mode = 1'b0; sel = '0; dwell = '0; last_line = '0;
      repeat (2) step();
      check("rst_out", 32'(out), 32'h0);
      check("rst_cur", 32'(cur_sel), 32'h0);
      check("rst_wrap", 32'(wrap), 32'h0);
      rst_n = 1'b1;
      step();

      // direct decode, one cycle latency
      enable = 1'b1; mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         step();
         check($sformatf("dir_out%0d", i), 32'(out), 32'(1) << i);
         check($sformatf("dir_cur%0d", i), 32'(cur_sel), 32'(i));
         check($sformatf("dir_wrap%0d", i), 32'(wrap), 32'h0);
      end
      enable = 1'b0;
      step();
      check("dis_out", 32'(out), 32'h0);
      check("dis_cur", 32'(cur_sel), 32'h0);

      // scan frame dwell=1, last_line=3
      enable = 1'b1; mode = 1'b1; dwell = 8'd1; last_line = 3'd3;
      for (int i = 0; i < f_n; i++) begin
         step();
         check($sformatf("frm_out%0d", i), 32'(out), 32'(f_out[i]));
         check($sformatf("frm_cur%0d", i), 32'(cur_sel), 32'(f_cur[i]));
         check($sformatf("frm_wrap%0d", i), 32'(wrap), (i == f_n - 1) ? 32'h1 : 32'h0);
      end

      // asynchronous reset mid-scan
      dwell = 8'd2; last_line = 3'd5;
      step();
      check("pre_rst_out", 32'(out), 32'h01);
      rst_n = 1'b0;
      #1;
      check("arst_out", 32'(out), 32'h0);
      check("arst_cur", 32'(cur_sel), 32'h0);
      check("arst_wrap", 32'(wrap), 32'h0);
      #2 rst_n = 1'b1;
      step();
      check("rel_out", 32'(out), 32'h01);
      check("rel_cur", 32'(cur_sel), 32'h0);
      check("rel_wrap", 32'(wrap), 32'h0);

      // dwell=0, last_line=0: line 0 held, wrap every line period
      enable = 1'b0;
      step();
      enable = 1'b1; dwell = 8'd0; last_line = 3'd0;
      step();
      check("l0_out", 32'(out), 32'h01);
      check("l0_wrap", 32'(wrap), 32'h0);
      for (int k = 0; k < 3; k++) begin
`ifdef DECODER_SCAN_BLANK_EN
         step();
         check($sformatf("l0_blank%0d", k), 32'(out), 32'h0);
         check($sformatf("l0_bwrap%0d", k), 32'(wrap), 32'h0);
`endif
         step();
         check($sformatf("l0_out%0d", k), 32'(out), 32'h01);
         check($sformatf("l0_wrap%0d", k), 32'(wrap), 32'h1);
      end

      // widen last_line mid-line: step through every line, then wrap
      last_line = 3'd7;
      for (int k = 1; k <= 8; k++) begin
`ifdef DECODER_SCAN_BLANK_EN
         step();
         check($sformatf("st_blank%0d", k), 32'(out), 32'h0);
         check($sformatf("st_bcur%0d", k), 32'(cur_sel), 32'(k % 8));
`endif
         step();
         check($sformatf("st_out%0d", k), 32'(out), 32'(1) << (k % 8));
         check($sformatf("st_wrap%0d", k), 32'(wrap), (k == 8) ? 32'h1 : 32'h0);
      end

      // lower last_line while line 5 is driven
      enable = 1'b0;
      step();
      enable = 1'b1; dwell = 8'd1; last_line = 3'd7;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (out == 8'h20) found = 1'b1;
      end
      check("l5_reach", 32'(found), 32'h1);
      last_line = 3'd2;
      step();
      check("l5_hold", 32'(out), 32'h20);
      check("l5_hcur", 32'(cur_sel), 32'h5);
`ifdef DECODER_SCAN_BLANK_EN
      step();
      check("l5_blank", 32'(out), 32'h0);
      check("l5_bcur", 32'(cur_sel), 32'h0);
      check("l5_bwrap", 32'(wrap), 32'h0);
`endif
      step();
      check("l5_wrap_out", 32'(out), 32'h01);
      check("l5_wrap", 32'(wrap), 32'h1);
      mode = 1'b0; sel = 3'd6;
      step();
      check("m2d_out", 32'(out), 32'h40);
      check("m2d_cur", 32'(cur_sel), 32'h6);

      // re-entry restarts at line 0; enable drop clears output
      mode = 1'b1;
      step();
      check("reent_out", 32'(out), 32'h01);
      check("reent_wrap", 32'(wrap), 32'h0);
      enable = 1'b0;
      step();
      check("drop_out", 32'(out), 32'h0);
      check("drop_cur", 32'(cur_sel), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
